// File: rtl/isp_program_loader.sv
// Byte-stream ISP loader: 4-byte word-count header, then little-endian
// 32-bit words written to consecutive addresses, then a single start pulse.
module isp_program_loader #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          ADDRESS_BITS = 12,
  parameter logic [19:0] PROG_ADDRESS = 20'h0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic                    isp_write,
  output logic [ADDRESS_BITS-1:0] isp_address,
  output logic [DATA_WIDTH-1:0]   isp_data,
  output logic                    start,
  output logic [19:0]             prog_address,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int          CW    = ADDRESS_BITS + 1;
  localparam logic [31:0] MAX_N = 32'(1) << ADDRESS_BITS;

  typedef enum logic [2:0] {
    S_HDR,
    S_LOAD,
    S_FLUSH,
    S_START,
    S_DONE,
    S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [1:0]              bcnt_q, bcnt_d;
  logic [DATA_WIDTH-9:0]   buf_q, buf_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           wcnt_q, wcnt_d;
  logic                    wr_q, wr_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;

  logic                  accept;
  logic                  last_byte;
  logic [DATA_WIDTH-1:0] word;
  logic                  too_big;
  logic                  hdr_zero;
  logic                  last_word;

  assign accept    = rx_valid & rx_ready;
  assign last_byte = accept & (bcnt_q == 2'd3);
  assign word      = {rx_byte, buf_q};
  assign too_big   = word > MAX_N;
  assign hdr_zero  = word == '0;
  assign last_word = wcnt_q == (cnt_q - CW'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_HDR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HDR: begin
        if (last_byte) begin
          if (too_big)       state_d = S_ERR;
          else if (hdr_zero) state_d = S_START;
          else               state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (last_byte && last_word) state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_START;
      S_START: state_d = S_DONE;
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    rx_ready     = 1'b0;
    start        = 1'b0;
    prog_address = 20'h0;
    busy         = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    unique case (1'b1)
      state_q == S_HDR: begin
        rx_ready = 1'b1;
        busy     = bcnt_q != 2'd0;
      end
      state_q == S_LOAD: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      state_q == S_FLUSH: busy = 1'b1;
      state_q == S_START: begin
        start        = 1'b1;
        prog_address = PROG_ADDRESS;
      end
      state_q == S_DONE: done = 1'b1;
      state_q == S_ERR: begin
        rx_ready = 1'b1;
        error    = 1'b1;
      end
      default: ;
    endcase
  end

  // Byte assembly; ERR drains bytes without touching the datapath.
  always_comb begin
    bcnt_d = bcnt_q;
    buf_d  = buf_q;
    cnt_d  = cnt_q;
    wcnt_d = wcnt_q;
    wr_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (accept && state_q != S_ERR) begin
      bcnt_d = bcnt_q + 2'd1;
      buf_d  = {rx_byte, buf_q[DATA_WIDTH-9:8]};
    end
    if (last_byte && state_q == S_HDR && !too_big) begin
      cnt_d = word[CW-1:0];
    end
    if (last_byte && state_q == S_LOAD) begin
      wr_d   = 1'b1;
      addr_d = wcnt_q[ADDRESS_BITS-1:0];
      data_d = word;
      wcnt_d = wcnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bcnt_q <= '0;
      buf_q  <= '0;
      cnt_q  <= '0;
      wcnt_q <= '0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      buf_q  <= buf_d;
      cnt_q  <= cnt_d;
      wcnt_q <= wcnt_d;
      wr_q   <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign isp_write   = wr_q;
  assign isp_address = addr_q;
  assign isp_data    = data_q;

endmodule

// File: tb/tb_isp_program_loader.sv
// Randomized bench for isp_program_loader with a byte-count based
// reference model and a per-cycle output compare.
module tb_isp_program_loader;

  localparam logic [19:0] PA = 20'h00400;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        isp_write;
  logic [11:0] isp_address;
  logic [31:0] isp_data;
  logic        start;
  logic [19:0] prog_address;
  logic        busy;
  logic        done;
  logic        error;

  isp_program_loader #(
    .DATA_WIDTH(32),
    .ADDRESS_BITS(12),
    .PROG_ADDRESS(PA)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .isp_write(isp_write),
    .isp_address(isp_address),
    .isp_data(isp_data),
    .start(start),
    .prog_address(prog_address),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 0;
  bit gaps = 0;

  // model state
  int          cyc = 0;
  int          nacc = 0;
  int          fin_cyc = 0;
  bit          fin = 0;
  bit          err = 0;
  logic [31:0] n_hdr = 0;
  logic [31:0] last4 = 0;
  bit          e_ready = 1;
  bit          e_write = 0;
  logic [11:0] e_addr = 0;
  logic [31:0] e_data = 0;
  bit          e_start = 0;
  bit          e_done = 0;
  bit          e_busy = 0;

  // observations of the DUT for literal end-of-test checks
  logic [43:0] wlog[$];
  int          nstarts = 0;

  task automatic chk(input string nm, input logic [43:0] act,
                     input logic [43:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  initial begin : model
    bit acc;
    int lat;
    forever begin
      @(posedge clock);
      cyc++;
      acc = !reset && rx_valid && e_ready;
      e_write = 0;
      if (reset) begin
        nacc = 0; fin = 0; err = 0; n_hdr = 0;
      end else if (acc) begin
        last4 = {rx_byte, last4[31:8]};
        nacc++;
        if (!err && nacc == 4) begin
          n_hdr = last4;
          if (n_hdr > 32'd4096) err = 1;
          else if (n_hdr == 0) begin fin = 1; fin_cyc = cyc; end
        end else if (!err && nacc > 4 && nacc % 4 == 0) begin
          e_write = 1;
          e_addr  = 12'(nacc / 4 - 2);
          e_data  = last4;
          if (32'(nacc / 4 - 1) == n_hdr) begin fin = 1; fin_cyc = cyc; end
        end
      end
      lat     = (n_hdr != 0) ? 1 : 0;
      e_ready = !fin;
      e_start = fin && cyc == fin_cyc + lat;
      e_done  = fin && cyc > fin_cyc + lat;
      e_busy  = !err && ((nacc >= 1 && !fin) ||
                         (fin && n_hdr != 0 && cyc == fin_cyc));
    end
  end

  initial begin : compare
    forever begin
      @(negedge clock);
      if (chk_en) begin
        chk("rx_ready", 44'(rx_ready), 44'(e_ready));
        chk("isp_write", 44'(isp_write), 44'(e_write));
        if (e_write) begin
          chk("isp_address", 44'(isp_address), 44'(e_addr));
          chk("isp_data", 44'(isp_data), 44'(e_data));
        end
        chk("start", 44'(start), 44'(e_start));
        chk("prog_address", 44'(prog_address), 44'(e_start ? PA : 20'h0));
        chk("done", 44'(done), 44'(e_done));
        chk("error", 44'(error), 44'(err));
        chk("busy", 44'(busy), 44'(e_busy));
        if (isp_write) wlog.push_back({isp_address, isp_data});
        if (start) nstarts++;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    bit acc;
    if (gaps && $urandom_range(0, 3) == 0) begin
      rx_valid = 1'b0;
      rx_byte  = 8'($urandom);
      repeat ($urandom_range(1, 3)) step();
    end
    rx_byte  = b;
    rx_valid = 1'b1;
    guard    = 0;
    forever begin
      acc = e_ready;
      step();
      if (acc) break;
      guard++;
      if (guard > 50) begin
        nvec++;
        nerr++;
        $display("FAIL send_timeout: got no accept expected accept");
        break;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(8'(w >> (8 * i)));
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'($urandom_range(0, 1));
    rx_byte  = 8'($urandom);
    step();
    step();
    reset    = 1'b0;
    rx_valid = 1'b0;
    wlog.delete();
    nstarts  = 0;
  endtask

  task automatic poke_ignored(input int n);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_byte  = 8'($urandom);
      step();
    end
    rx_valid = 1'b0;
  endtask

  initial begin : stim
    step();
    chk_en = 1;
    do_reset();
    chk("rst_rx_ready", 44'(rx_ready), 44'd1);
    chk("rst_isp_address", 44'(isp_address), 44'd0);
    chk("rst_isp_data", 44'(isp_data), 44'd0);
    chk("rst_flags", 44'({isp_write, start, busy, done, error}), 44'd0);

    // two-word program
    send_word(32'd2);
    send_word(32'h00000513);
    send_word(32'h00100593);
    repeat (4) step();
    poke_ignored(3);
    chk("t1_nwrites", 44'(wlog.size()), 44'd2);
    if (wlog.size() == 2) begin
      chk("t1_w0", wlog[0], {12'h000, 32'h00000513});
      chk("t1_w1", wlog[1], {12'h001, 32'h00100593});
    end
    chk("t1_starts", 44'(nstarts), 44'd1);
    chk("t1_done", 44'(done), 44'd1);

    // empty program
    do_reset();
    send_word(32'd0);
    repeat (3) step();
    chk("t2_nwrites", 44'(wlog.size()), 44'd0);
    chk("t2_starts", 44'(nstarts), 44'd1);
    chk("t2_done_ready", 44'({done, rx_ready}), 44'b10);

    // oversize header, then drain
    do_reset();
    send_word(32'h00001001);
    for (int i = 0; i < 16; i++) send_byte(8'($urandom));
    repeat (3) step();
    chk("t3_error", 44'(error), 44'd1);
    chk("t3_nwrites", 44'(wlog.size()), 44'd0);
    chk("t3_starts", 44'(nstarts), 44'd0);

    // maximum program with random gaps
    do_reset();
    gaps = 1;
    send_word(32'd4096);
    for (int i = 0; i < 4096; i++) send_word($urandom);
    repeat (4) step();
    chk("t4_nwrites", 44'(wlog.size()), 44'd4096);
    if (wlog.size() > 0) chk("t4_last_addr", 44'(wlog[$][43:32]), 44'hFFF);
    chk("t4_starts", 44'(nstarts), 44'd1);

    // abandoned load, then a fresh one-word load
    do_reset();
    gaps = 0;
    send_word(32'd3);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom));
    do_reset();
    send_word(32'd1);
    send_word(32'hDEADBEEF);
    repeat (4) step();
    chk("t5_nwrites", 44'(wlog.size()), 44'd1);
    if (wlog.size() == 1) chk("t5_w0", wlog[0], {12'h000, 32'hDEADBEEF});
    chk("t5_starts", 44'(nstarts), 44'd1);

    // a few short random programs
    gaps = 1;
    for (int t = 0; t < 4; t++) begin
      int n;
      n = $urandom_range(1, 20);
      do_reset();
      send_word(32'(n));
      for (int i = 0; i < n; i++) send_word($urandom);
      repeat (4) step();
      chk("tr_nwrites", 44'(wlog.size()), 44'(n));
      chk("tr_starts", 44'(nstarts), 44'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
